// File: rtl/sfq_arith_pkg.sv
// Shared types and constants for the serial adder sequencer.
// Also used by the pipelined full-adder wrapper.
package sfq_arith_pkg;

  localparam int FA_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sa_state_e;

endpackage

// File: rtl/sfq_wait_timer.sv
// Loadable down-counter that spans the adder pipeline latency.
// zero is high once the count reaches 0 and stays until reloaded.
module sfq_wait_timer
  import sfq_arith_pkg::*;
#(
  parameter int ADDER_LAT = FA_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CW = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload on issue, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(ADDER_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_adder_sequencer.sv
// Drives a pipelined 1-bit full adder LSB-first to build a WIDTH-bit sum.
// Carry is captured from the adder and fed back on the next issue.
module serial_adder_sequencer
  import sfq_arith_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDER_LAT = FA_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             tmr_load;
  logic             tmr_zero;

  sfq_wait_timer #(
    .ADDER_LAT(ADDER_LAT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .zero(tmr_zero)
  );

  // Next-state, datapath updates and outputs.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    tmr_load = 1'b0;
    done     = 1'b0;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_cin   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          res_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fa_a     = a_q[0];
        fa_b     = b_q[0];
        fa_cin   = carry_q;
        tmr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          res_d[idx_q] = fa_sum;
          carry_d      = fa_cout;
          a_d          = a_q >> 1;
          b_d          = b_q >> 1;
          if (idx_q == LAST) begin
            cout_d  = fa_cout;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Bench for serial_adder_sequencer: two instances (8b/lat4, 4b/lat1)
// each with a clocked full-adder pipeline model on its fa_* port.
module tb_serial_adder_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel   = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a  = '0;
  logic [7:0] op_b  = '0;
  logic       cin   = 1'b0;

  logic       start8, busy8, done8, cout8;
  logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
  logic [7:0] result8;
  logic       start4, busy4, done4, cout4;
  logic       fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4;
  logic [3:0] result4;

  assign start8 = start & ~sel;
  assign start4 = start & sel;

  serial_adder_sequencer #(.WIDTH(8), .ADDER_LAT(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8),
    .fa_sum(fa_sum8), .fa_cout(fa_cout8)
  );

  serial_adder_sequencer #(.WIDTH(4), .ADDER_LAT(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .op_a(op_a[3:0]), .op_b(op_b[3:0]), .cin(cin),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4),
    .fa_sum(fa_sum4), .fa_cout(fa_cout4)
  );

  // Pipelined full adders: 4 register stages and 1 register stage.
  logic [1:0] p8 [4] = '{default: 2'b00};
  logic [1:0] p4 = 2'b00;
  always @(posedge clk) begin
    p8[0] <= {(fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8)),
              fa_a8 ^ fa_b8 ^ fa_cin8};
    for (int i = 1; i < 4; i++) p8[i] <= p8[i-1];
    p4 <= {(fa_a4 & fa_b4) | (fa_cin4 & (fa_a4 ^ fa_b4)),
           fa_a4 ^ fa_b4 ^ fa_cin4};
  end
  assign fa_sum8  = p8[3][0];
  assign fa_cout8 = p8[3][1];
  assign fa_sum4  = p4[0];
  assign fa_cout4 = p4[1];

  logic       busy_m, done_m, cout_m, fa_any_m, fa_cin_m;
  logic [7:0] result_m;
  assign busy_m   = sel ? busy4 : busy8;
  assign done_m   = sel ? done4 : done8;
  assign cout_m   = sel ? cout4 : cout8;
  assign result_m = sel ? {4'h0, result4} : result8;
  assign fa_cin_m = sel ? fa_cin4 : fa_cin8;
  assign fa_any_m = sel ? (fa_a4 | fa_b4 | fa_cin4)
                        : (fa_a8 | fa_b8 | fa_cin8);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_done"}, done_m, 0);
    check({tag, "_result"}, result_m, 0);
    check({tag, "_cout"}, cout_m, 0);
    check({tag, "_fa"}, fa_any_m, 0);
  endtask

  // One operation from start to the idle cycle after done.
  // restart_at: cycle (relative to acceptance) to re-pulse start, 0 = none.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int restart_at,
                        output logic [7:0] cin_bits);
    int         w, l, d, done_at, ndone, bad_fa, bad_busy, bitn;
    logic [7:0] mask, exp_res, res_at_done;
    logic [8:0] full;
    logic       exp_cout, cout_at_done;
    w = sel ? 4 : 8;
    l = sel ? 1 : 4;
    d = w * (l + 1) + 1;
    mask = sel ? 8'h0F : 8'hFF;
    full = {1'b0, a & mask} + {1'b0, b & mask} + 9'(c);
    exp_res = full[7:0] & mask;
    exp_cout = full[w];
    done_at = -1; ndone = 0; bad_fa = 0; bad_busy = 0;
    res_at_done = '0; cout_at_done = 1'b0; cin_bits = '0;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    for (int cy = 1; cy <= d; cy++) begin
      bitn = (cy - 1) / (l + 1);
      if (((cy - 1) % (l + 1) == 0) && bitn < w) begin
        cin_bits[bitn] = fa_cin_m;
      end else if (fa_any_m) begin
        bad_fa++;
      end
      if (!busy_m) bad_busy++;
      if (done_m) begin
        ndone++;
        if (done_at < 0) done_at = cy;
        res_at_done = result_m;
        cout_at_done = cout_m;
      end
      if (cy == restart_at) begin
        start = 1'b1; op_a = 8'h00;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("done_cycle", done_at, d);
    check("done_count", ndone, 1);
    check("result", res_at_done, exp_res);
    check("cout", cout_at_done, exp_cout);
    check("fa_idle_zero", bad_fa, 0);
    check("busy_window", bad_busy, 0);
    check("idle_busy", busy_m, 0);
    check("idle_done", done_m, 0);
    check("result_held", result_m, exp_res);
  endtask

  logic [7:0] cb;
  logic [7:0] ra, rb;
  logic       rc;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, 0, cb);
    run_op(8'hFF, 8'h01, 1'b0, 0, cb);
    check("fa_cin_bits7_1", cb[7:1], 7'h7F);
    run_op(8'hFF, 8'hFF, 1'b1, 0, cb);
    check("fa_cin_bit0", cb[0], 1);
    run_op(8'h12, 8'h34, 1'b0, 10, cb);
    run_op(8'h12, 8'h34, 1'b0, 41, cb);

    op_a = 8'hA5; op_b = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cy = 1; cy < 16; cy++) tick();
    check("pre_rst_busy", busy_m, 1);
    check("pre_rst_bit0", result_m[0], 1);
    rst = 1'b1;
    #1;
    check_quiet("rst_async");
    tick();
    check_quiet("rst_next");
    rst = 1'b0;
    tick();
    run_op(8'h5A, 8'h3C, 1'b0, 0, cb);

    sel = 1'b1;
    tick();
    run_op(8'h09, 8'h08, 1'b0, 0, cb);
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      rc = 1'($urandom);
      run_op(ra, rb, rc, 0, cb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
